// File: rtl/gpr_write_port.sv
// GPR write side: 32-entry array, ALU/load writeback arbitration, rs1/rs2 read ports.
// Optional `GPR_WB_BYPASS_EN forwards the committing write to the read ports in the same cycle.
module gpr_write_port #(
    parameter  int XLEN           = 32,
    parameter  int NREG           = 32,
    parameter  int ALU_FIFO_DEPTH = 2,
    localparam int AW             = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_resetn,
    input  logic            i_alu_valid,
    output logic            o_alu_ready,
    input  logic [AW-1:0]   i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    input  logic            i_ld_valid,
    output logic            o_ld_ready,
    input  logic [AW-1:0]   i_ld_rd,
    input  logic [XLEN-1:0] i_ld_data,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic            o_init_done,
    output logic            o_wr_en,
    output logic [AW-1:0]   o_wr_addr,
    output logic [XLEN-1:0] o_wr_data
);

    localparam int PW = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             clr_cnt_q;
    logic                      clearing, running;

    logic [XLEN-1:0]           regs [NREG];

    logic [AW-1:0]             fifo_rd   [ALU_FIFO_DEPTH];
    logic [XLEN-1:0]           fifo_data [ALU_FIFO_DEPTH];
    logic [ALU_FIFO_DEPTH-1:0] slot_valid_q, slot_valid_d;
    logic [PW-1:0]             wptr_q, rptr_q;
    logic                      full, empty;

    logic                      ld_hazard, alu_fire, ld_fire, push, ld_write, pop;
    logic                      arr_we;
    logic [AW-1:0]             arr_waddr;
    logic [XLEN-1:0]           arr_wdata;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(ALU_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q   <= CLEAR;
            clr_cnt_q <= AW'(1);
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR)
                clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        clearing    = 1'b0;
        running     = 1'b0;
        o_init_done = 1'b0;
        o_alu_ready = 1'b0;
        o_ld_ready  = 1'b0;
        case (state_q)
            CLEAR: begin
                clearing = 1'b1;
                if (clr_cnt_q == AW'(NREG - 1))
                    state_d = RUN;
            end
            RUN: begin
                running     = 1'b1;
                o_init_done = 1'b1;
                o_alu_ready = !full;
                o_ld_ready  = !full && !ld_hazard;
            end
            default: state_d = CLEAR;
        endcase
    end

    // Loads may not overtake a buffered ALU write to the same register.
    always_comb begin
        ld_hazard = 1'b0;
        for (int unsigned i = 0; i < ALU_FIFO_DEPTH; i++)
            if (slot_valid_q[i] && fifo_rd[i] == i_ld_rd)
                ld_hazard = 1'b1;
    end

    assign full     = &slot_valid_q;
    assign empty    = ~|slot_valid_q;
    assign alu_fire = i_alu_valid && o_alu_ready;
    assign ld_fire  = i_ld_valid && o_ld_ready;
    assign push     = alu_fire && (i_alu_rd != '0);
    assign ld_write = ld_fire && (i_ld_rd != '0);
    // A full FIFO always drains; otherwise the head yields only to a real load write.
    assign pop      = running && !empty && (full || !ld_write);

    always_comb begin
        slot_valid_d = slot_valid_q;
        if (pop)
            slot_valid_d[rptr_q] = 1'b0;
        if (push)
            slot_valid_d[wptr_q] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            slot_valid_q <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            if (push)
                wptr_q <= ptr_inc(wptr_q);
            if (pop)
                rptr_q <= ptr_inc(rptr_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_rd[wptr_q]   <= i_alu_rd;
            fifo_data[wptr_q] <= i_alu_data;
        end
    end

    always_comb begin
        o_wr_en   = 1'b0;
        o_wr_addr = '0;
        o_wr_data = '0;
        if (pop) begin
            o_wr_en   = 1'b1;
            o_wr_addr = fifo_rd[rptr_q];
            o_wr_data = fifo_data[rptr_q];
        end else if (ld_write) begin
            o_wr_en   = 1'b1;
            o_wr_addr = i_ld_rd;
            o_wr_data = i_ld_data;
        end
    end

    // Storage has no reset; gating on i_resetn drops the in-flight write.
    assign arr_we    = i_resetn && (clearing || o_wr_en);
    assign arr_waddr = clearing ? clr_cnt_q : o_wr_addr;
    assign arr_wdata = clearing ? '0 : o_wr_data;

    always_ff @(posedge i_clk) begin
        if (arr_we)
            regs[arr_waddr] <= arr_wdata;
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        if (!running || a == '0)
            return '0;
`ifdef GPR_WB_BYPASS_EN
        else if (o_wr_en && a == o_wr_addr)
            return o_wr_data;
`endif
        else
            return regs[a];
    endfunction

    always_comb begin
        o_rs1_data = read_port(i_rs1_addr);
        o_rs2_data = read_port(i_rs2_addr);
    end

endmodule

// File: tb/tb_gpr_write_port.sv
// Scoreboard bench for gpr_write_port: expected commits queued at stimulus time,
// a negedge monitor checks every o_wr_en pulse against the queue.
module tb_gpr_write_port;

    logic        clk;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        init_done;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    gpr_write_port #(
        .XLEN(32),
        .NREG(32),
        .ALU_FIFO_DEPTH(2)
    ) dut (
        .i_clk      (clk),
        .i_resetn   (rst_n),
        .i_alu_valid(alu_valid),
        .o_alu_ready(alu_ready),
        .i_alu_rd   (alu_rd),
        .i_alu_data (alu_data),
        .i_ld_valid (ld_valid),
        .o_ld_ready (ld_ready),
        .i_ld_rd    (ld_rd),
        .i_ld_data  (ld_data),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .o_rs1_data (rs1_data),
        .o_rs2_data (rs2_data),
        .o_init_done(init_done),
        .o_wr_en    (wr_en),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL commit: got addr=%0d data=%h expected addr=%0d data=%h",
                             wr_addr, wr_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (n < 100) begin
            step();
            n++;
            if (init_done) break;
        end
        check(name, n, 31);
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0;
        rs1_addr = 5'd5;  rs2_addr = 5'd9;
        repeat (3) step();

        check("rst_alu_ready", alu_ready, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_init_done", init_done, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rs1", rs1_data, 0);

        // Clear sequence length and cleared contents
        rst_n = 1'b1;
        wait_init("init_cycles");
        check("init_alu_ready", alu_ready, 1);
        check("init_ld_ready", ld_ready, 1);
        for (int i = 1; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(32 - i);
            #1;
            check("clear_rs1", rs1_data, 0);
            check("clear_rs2", rs2_data, 0);
        end

        // ALU write x5, read-after-write
        step();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        check("alu5_ready", alu_ready, 1);
        expect_wr(5'd5, 32'hDEADBEEF);
        step();
        alu_valid = 1'b0;
        rs1_addr = 5'd5;
        #1;
        check("alu5_wr_en", wr_en, 1);
`ifdef GPR_WB_BYPASS_EN
        check("x5_commit_cycle", rs1_data, 32'hDEADBEEF);
`else
        check("x5_commit_cycle", rs1_data, 32'h0);
`endif
        step();
        check("x5_after", rs1_data, 32'hDEADBEEF);

        // Load and ALU together: load first
        ld_valid = 1'b1;  ld_rd = 5'd7;  ld_data = 32'h1234;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55;
        #1;
        check("both_ld_ready", ld_ready, 1);
        expect_wr(5'd7, 32'h1234);
        expect_wr(5'd9, 32'h55);
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        step();
        rs1_addr = 5'd7; rs2_addr = 5'd9;
        #1;
        check("x7", rs1_data, 32'h1234);
        check("x9", rs2_data, 32'h55);

        // Same-rd hazard: load x3 waits for buffered ALU x3
        ld_valid = 1'b1;  ld_rd = 5'd10; ld_data = 32'h10;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA;
        expect_wr(5'd10, 32'h10);
        expect_wr(5'd3, 32'hAAAA);
        expect_wr(5'd3, 32'h3333);
        step();
        alu_valid = 1'b0;
        ld_rd = 5'd3; ld_data = 32'h3333;
        #1;
        check("hazard_ld_ready", ld_ready, 0);
        step();
        check("hazard_clear_ld_ready", ld_ready, 1);
        step();
        ld_valid = 1'b0;
        rs1_addr = 5'd3; rs2_addr = 5'd10;
        #1;
        check("x3_final", rs1_data, 32'h3333);
        check("x10", rs2_data, 32'h10);

        // FIFO fills under continuous loads; head preempts
        ld_valid = 1'b1;  ld_rd = 5'd11; ld_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h12;
        expect_wr(5'd11, 32'h11);
        expect_wr(5'd13, 32'h13);
        expect_wr(5'd12, 32'h12);
        expect_wr(5'd15, 32'h15);
        expect_wr(5'd14, 32'h14);
        step();
        ld_rd = 5'd13; ld_data = 32'h13;
        alu_rd = 5'd14; alu_data = 32'h14;
        #1;
        check("fill_ld_ready", ld_ready, 1);
        check("fill_alu_ready", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        ld_rd = 5'd15; ld_data = 32'h15;
        #1;
        check("full_ld_ready", ld_ready, 0);
        check("full_alu_ready", alu_ready, 0);
        step();
        check("drain_ld_ready", ld_ready, 1);
        step();
        ld_valid = 1'b0;
        step();
        rs1_addr = 5'd12; rs2_addr = 5'd14;
        #1;
        check("x12", rs1_data, 32'h12);
        check("x14", rs2_data, 32'h14);
        rs1_addr = 5'd15; rs2_addr = 5'd11;
        #1;
        check("x15", rs1_data, 32'h15);
        check("x11", rs2_data, 32'h11);

        // Writes to x0 are accepted but dropped
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
        #1;
        check("x0_alu_ready", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        #1;
        check("x0_alu_no_wr", wr_en, 0);
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFFFFFF;
        #1;
        check("x0_ld_ready", ld_ready, 1);
        check("x0_ld_no_wr", wr_en, 0);
        step();
        ld_valid = 1'b0;
        rs1_addr = 5'd0;
        #1;
        check("x0_read", rs1_data, 0);

        // Reset with x21 in the FIFO and its write in flight
        ld_valid = 1'b1;  ld_rd = 5'd22; ld_data = 32'h22;
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h21;
        expect_wr(5'd22, 32'h22);
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        #1;
        check("inflight_wr_en", wr_en, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en", wr_en, 0);
        check("midrst_init_done", init_done, 0);
        check("midrst_alu_ready", alu_ready, 0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_init("reinit_cycles");
        rs1_addr = 5'd21; rs2_addr = 5'd22;
        ld_rd = 5'd21;
        #1;
        check("x21_dropped", rs1_data, 0);
        check("x22_recleared", rs2_data, 0);
        check("flushed_ld_ready", ld_ready, 1);
        check("flushed_wr_en", wr_en, 0);
        repeat (3) step();

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
